wram_hs_arbiter: RTL and testbench

//  Shares the single-port work RAM between the Z80 and the hiscore engine. On a hiscore

---
 rtl/wram_hs_arbiter.sv | 115 +++++++++++
 tb/tb_wram_hs_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wram_hs_arbiter.sv
// Arbitrates the single-port work RAM between the Z80 and the hiscore engine.
// The CPU is paused and allowed to settle before the hiscore engine gets the port; the CPU then always gets at least one release window.
module wram_hs_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int SETTLE       = 4,
  parameter int IDLE_RELEASE = 16
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_ce,
  input  logic          user_pause,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_we,
  input  logic [DW-1:0] hs_wdata,
  input  logic          hs_intent_read,
  input  logic          hs_intent_write,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_granted,
  output logic          pause_cpu,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_GUARD} state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);
  localparam logic [7:0] IDLE_LAST   = 8'(IDLE_RELEASE - 1);

  state_e        state_q, state_d;
  logic [3:0]    settle_q, settle_d;
  logic [7:0]    idle_q, idle_d;
  logic [DW-1:0] hs_rdata_q;
  logic          intent;

  assign intent = hs_intent_read | hs_intent_write;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      idle_q     <= '0;
      hs_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idle_q   <= idle_d;
      if (state_q == S_GRANT) begin
        hs_rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idle_d   = idle_q;
    case (state_q)
      S_IDLE: begin
        if (intent) begin
          state_d  = S_REQ;
          settle_d = SETTLE_INIT;
        end
      end
      S_REQ: begin
        // Grant lands on the cycle right after the final settling cpu_ce.
        if (!intent) begin
          state_d = S_GUARD;
        end else if (settle_q == 4'd0) begin
          state_d = S_GRANT;
          idle_d  = '0;
        end else if (cpu_ce) begin
          settle_d = settle_q - 4'd1;
          if (settle_q == 4'd1) begin
            state_d = S_GRANT;
            idle_d  = '0;
          end
        end
      end
      S_GRANT: begin
        if (intent) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_GUARD;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      S_GUARD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hs_granted = (state_q == S_GRANT);
  assign pause_cpu  = (state_q != S_IDLE) | user_pause;
  assign ram_addr   = hs_granted ? hs_addr  : cpu_addr;
  assign ram_wdata  = hs_granted ? hs_wdata : cpu_wdata;
  // GUARD blanks CPU writes for the cycle the port swings back.
  assign ram_we     = hs_granted ? (hs_we & hs_intent_write)
                                 : ((state_q == S_GUARD) ? 1'b0 : cpu_we);
  assign cpu_rdata  = ram_rdata;
  assign hs_rdata   = hs_rdata_q;

endmodule

// File: tb/tb_wram_hs_arbiter.sv
// Bench for wram_hs_arbiter: synchronous RAM model, randomized cpu_ce/intent
// patterns checked against cycle-count rules derived from the arbiter's behaviour.
module tb_wram_hs_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SETTLE = 4;
  localparam int IDLE_RELEASE = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n, cpu_ce, user_pause;
  logic [AW-1:0] cpu_addr, hs_addr, ram_addr;
  logic          cpu_we, hs_we, ram_we;
  logic [DW-1:0] cpu_wdata, cpu_rdata, hs_wdata, hs_rdata, ram_wdata, ram_rdata;
  logic          hs_intent_read, hs_intent_write, hs_granted, pause_cpu;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_dat;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [AW-1:0] rd_addr [$];
  logic [DW-1:0] rd_exp  [$];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ram_addr;
      wr_data <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  wram_hs_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .IDLE_RELEASE(IDLE_RELEASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_ce(cpu_ce), .user_pause(user_pause),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .hs_addr(hs_addr), .hs_we(hs_we), .hs_wdata(hs_wdata),
    .hs_intent_read(hs_intent_read), .hs_intent_write(hs_intent_write),
    .hs_rdata(hs_rdata), .hs_granted(hs_granted), .pause_cpu(pause_cpu),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic acquire(input bit wr);
    hs_intent_read  = !wr;
    hs_intent_write = wr;
    for (int i = 0; i < 100 && !hs_granted; i++) begin
      cyc();
      cpu_ce = 1'b1;
    end
    cyc();
    cpu_ce = 1'b0;
    smp();
    checks++;
    if (hs_granted !== 1'b1) begin
      errors++;
      $display("FAIL acquire: hs_granted=%b expected 1", hs_granted);
    end
  endtask

  task automatic test_reset_state();
    reset_n = 1'b0; cpu_ce = 0; user_pause = 0; cpu_addr = 12'h3C5; cpu_we = 0; cpu_wdata = 0;
    hs_addr = 12'h111; hs_we = 0; hs_wdata = 0; hs_intent_read = 0; hs_intent_write = 0;
    pre_we = 0; pre_addr = 0; pre_dat = 0;
    repeat (2) cyc();
    smp();
    checks += 4;
    if (hs_granted !== 1'b0) begin errors++; $display("FAIL rst_granted: got %b want 0", hs_granted); end
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL rst_pause: got %b want 0", pause_cpu); end
    if (hs_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", hs_rdata); end
    if (ram_addr !== 12'h3C5) begin errors++; $display("FAIL rst_addr: got %h want 3c5", ram_addr); end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic preload();
    logic [AW-1:0] a [6];
    logic [DW-1:0] d [6];
    a = '{12'h0B0, 12'h0B1, 12'h0B2, 12'h0B3, 12'h123, 12'h0A4};
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h00};
    for (int i = 0; i < 6; i++) begin
      cyc();
      pre_we = 1'b1; pre_addr = a[i]; pre_dat = d[i];
    end
    cyc();
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr.push_back(a[i]);
      rd_exp.push_back(d[i]);
    end
  endtask

  // Grant must appear exactly on the cycle after the SETTLE-th cpu_ce seen in REQ.
  task automatic test_settle(input bit periodic, input bit up);
    int n;
    bit ce;
    bit done;
    n = 0; done = 0;
    user_pause = up;
    cyc();
    hs_intent_write = 1'b1; hs_intent_read = 1'b0; cpu_ce = 1'b0;
    smp();
    checks += 2;
    if (pause_cpu !== up) begin errors++; $display("FAIL settle_pause0: got %b want %b", pause_cpu, up); end
    if (hs_granted !== 1'b0) begin errors++; $display("FAIL settle_grant0: got %b want 0", hs_granted); end
    for (int c = 1; c < 200; c++) begin
      cyc();
      ce = periodic ? (c % 4 == 0) : 1'($urandom_range(0, 1));
      cpu_ce = ce;
      smp();
      checks += 2;
      if (pause_cpu !== 1'b1) begin errors++; $display("FAIL settle_pause c=%0d: got %b want 1", c, pause_cpu); end
      if (hs_granted !== (n >= SETTLE)) begin
        errors++;
        $display("FAIL settle_grant c=%0d ce_seen=%0d: got %b want %b", c, n, hs_granted, n >= SETTLE);
      end
      if (n >= SETTLE) begin done = 1; break; end
      if (ce) n++;
    end
    cpu_ce = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL settle_timeout: ce_seen=%0d want %0d", n, SETTLE); end
  endtask

  task automatic test_write();
    int base;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    base = wr_cnt;
    cyc();
    cpu_we = 1'b1; cpu_addr = 12'h0A5; cpu_wdata = 8'hEE;
    hs_addr = 12'h0A4; hs_wdata = 8'h5C; hs_we = 1'b1;
    smp();
    checks += 3;
    if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", ram_we); end
    if (ram_addr !== 12'h0A4) begin errors++; $display("FAIL wr_addr: got %h want 0a4", ram_addr); end
    if (ram_wdata !== 8'h5C) begin errors++; $display("FAIL wr_data: got %h want 5c", ram_wdata); end
    cyc();
    hs_we = 1'b0;
    smp();
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_cpu_blocked: ram_we got %b want 0", ram_we); end
    cyc();
    smp();
    checks += 3;
    if (wr_cnt - base !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_cnt - base); end
    if (wr_addr !== 12'h0A4) begin errors++; $display("FAIL wr_last_addr: got %h want 0a4", wr_addr); end
    if (wr_data !== 8'h5C) begin errors++; $display("FAIL wr_last_data: got %h want 5c", wr_data); end
    cpu_we = 1'b0;
    rd_addr.push_back(12'h0A4);
    rd_exp.push_back(8'h5C);
    for (int i = 0; i < 4; i++) begin
      a = 12'h200 + AW'(i * 8) + AW'($urandom_range(0, 7));
      d = 8'($urandom);
      cyc();
      hs_we = 1'b1; hs_addr = a; hs_wdata = d;
      smp();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== a) begin
        errors++;
        $display("FAIL wr_rand%0d: we/addr got %b/%h want 1/%h", i, ram_we, ram_addr, a);
      end
      rd_addr.push_back(a);
      rd_exp.push_back(d);
    end
    cyc();
    hs_we = 1'b0;
  endtask

  task automatic test_read();
    int n;
    n = rd_addr.size();
    hs_intent_read = 1'b1; hs_intent_write = 1'b0;
    for (int k = 0; k < n + 2; k++) begin
      cyc();
      hs_we = (k == 1);
      if (k < n) hs_addr = rd_addr[k];
      smp();
      if (k == 1) begin
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we_no_intent: got %b want 0", ram_we); end
      end
      if (k >= 2) begin
        checks++;
        if (hs_rdata !== rd_exp[k-2]) begin
          errors++;
          $display("FAIL rd_data addr=%h: got %h want %h", rd_addr[k-2], hs_rdata, rd_exp[k-2]);
        end
      end
    end
    hs_we = 1'b0;
  endtask

  // Release happens once IDLE_RELEASE consecutive intent-low cycles have elapsed in GRANT.
  task automatic test_release(input bit reraise);
    int run;
    bit it;
    bit hit;
    run = 0; hit = 0;
    cpu_we = 1'b1; cpu_addr = 12'h3F0; cpu_wdata = 8'h77; hs_addr = 12'h0F0;
    for (int c = 0; c < 80; c++) begin
      cyc();
      it = (c < 20) ? ($urandom_range(0, 9) == 0) : 1'b0;
      if (run >= IDLE_RELEASE) it = reraise;
      hs_intent_read = it;
      smp();
      checks++;
      if (hs_granted !== (run < IDLE_RELEASE)) begin
        errors++;
        $display("FAIL rel_grant c=%0d low_run=%0d: got %b want %b", c, run, hs_granted, run < IDLE_RELEASE);
      end
      if (run >= IDLE_RELEASE) begin
        hit = 1;
        checks += 3;
        if (pause_cpu !== 1'b1) begin errors++; $display("FAIL guard_pause: got %b want 1", pause_cpu); end
        if (ram_we !== 1'b0) begin errors++; $display("FAIL guard_we: got %b want 0", ram_we); end
        if (ram_addr !== 12'h3F0) begin errors++; $display("FAIL guard_addr: got %h want 3f0", ram_addr); end
        break;
      end
      if (it) run = 0; else run++;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rel_timeout: low_run=%0d", run); end
    cyc();
    smp();
    checks += 2;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL idle_pause: got %b want 0", pause_cpu); end
    if (ram_we !== 1'b1) begin errors++; $display("FAIL idle_cpu_we: got %b want 1", ram_we); end
    cyc();
    cpu_we = 1'b0;
    smp();
    checks++;
    if (pause_cpu !== reraise) begin errors++; $display("FAIL rel_next_pause: got %b want %b", pause_cpu, reraise); end
    hs_intent_read = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_isolation();
    bit w;
    hs_we = 1'b1; hs_addr = 12'h123; hs_wdata = 8'h00;
    hs_intent_read = 1'b0; hs_intent_write = 1'b0; cpu_ce = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      if (c == 4) hs_intent_write = 1'b1;
      w = 1'($urandom_range(0, 1));
      cpu_we = w; cpu_addr = 12'h400 + AW'($urandom_range(0, 255)); cpu_wdata = 8'($urandom);
      smp();
      checks += 3;
      if (ram_we !== w) begin errors++; $display("FAIL iso_we c=%0d: got %b want %b", c, ram_we, w); end
      if (ram_addr !== cpu_addr) begin errors++; $display("FAIL iso_addr c=%0d: got %h want %h", c, ram_addr, cpu_addr); end
      if (hs_granted !== 1'b0) begin errors++; $display("FAIL iso_grant c=%0d: got %b want 0", c, hs_granted); end
    end
    cyc();
    cpu_we = 1'b0; hs_we = 1'b0; hs_intent_write = 1'b0;
    repeat (3) cyc();
    smp();
    checks++;
    if (mem[12'h123] !== 8'hA5) begin errors++; $display("FAIL iso_mem: got %h want a5", mem[12'h123]); end
  endtask

  task automatic test_abort();
    bit seen;
    seen = 0;
    cpu_we = 1'b1; cpu_addr = 12'h500; cpu_wdata = 8'h3C;
    for (int c = 0; c < 8; c++) begin
      cyc();
      hs_intent_read = (c < 3);
      cpu_ce = (c == 1 || c == 2);
      smp();
      if (hs_granted === 1'b1) seen = 1;
      if (c == 4) begin
        checks += 2;
        if (pause_cpu !== 1'b1) begin errors++; $display("FAIL abort_guard_pause: got %b want 1", pause_cpu); end
        if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_guard_we: got %b want 0", ram_we); end
      end
      if (c >= 5) begin
        checks++;
        if (pause_cpu !== 1'b0) begin errors++; $display("FAIL abort_idle_pause c=%0d: got %b want 0", c, pause_cpu); end
      end
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_grant: got 1 want never"); end
    cpu_we = 1'b0; cpu_ce = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    cyc();
    cpu_addr = 12'h7AB; hs_addr = 12'h111;
    #2;
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (hs_granted !== 1'b0) begin errors++; $display("FAIL rstg_grant: got %b want 0", hs_granted); end
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL rstg_pause_user: got %b want 1", pause_cpu); end
    if (ram_addr !== 12'h7AB) begin errors++; $display("FAIL rstg_addr: got %h want 7ab", ram_addr); end
    if (hs_rdata !== 8'h00) begin errors++; $display("FAIL rstg_rdata: got %h want 00", hs_rdata); end
    user_pause = 1'b0;
    #1;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL rstg_pause: got %b want 0", pause_cpu); end
    hs_intent_read = 1'b0; hs_intent_write = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset_state();
    preload();
    test_settle(1'b1, 1'b0);
    test_write();
    test_read();
    test_release(1'b0);
    acquire(1'b0);
    test_release(1'b1);
    test_isolation();
    test_abort();
    test_settle(1'b0, 1'b1);
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
